// File: rtl/sif_xa_master.sv
// SIF X-side access initiator: queues host commands and issues them as
// single-cycle read/write strobes, returning read data on a valid/ready port.
module sif_xa_master #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int RD_LAT    = 2,
    parameter int GAP       = 0,
    parameter int CMD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd,
    output logic          busy,
    output logic [15:0]   wr_cnt,
    output logic [15:0]   rd_cnt
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RESP,
        S_GAPW
    } state_t;

    state_t state;
    state_t next_issue;

    logic          fifo_wr    [CMD_DEPTH];
    logic [AW-1:0] fifo_addr  [CMD_DEPTH];
    logic [DW-1:0] fifo_wdata [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic             push;
    logic             pop;
    logic             issue_slot;
    logic             fifo_empty;
    logic [AW-1:0]    cur_addr;
    logic [DW-1:0]    cur_wdata;
    logic [LAT_W-1:0] lat_cnt;
    logic [3:0]       gap_cnt;

    // A slot opens wherever the FSM is free to start the next command; with
    // GAP = 0 that includes the strobe and handshake cycles, giving back-to-back issue.
    always_comb begin
        push       = cmd_valid && cmd_ready;
        fifo_empty = (count == '0);
        next_issue = fifo_wr[rd_ptr] ? S_WR : S_RD;
        case (state)
            S_IDLE:  issue_slot = 1'b1;
            S_WR:    issue_slot = (GAP == 0);
            S_RESP:  issue_slot = rsp_ready && (GAP == 0);
            S_GAPW:  issue_slot = (gap_cnt == 4'd0);
            default: issue_slot = 1'b0;
        endcase
        pop        = issue_slot && !fifo_empty;
        count_next = count;
        if (push && !pop)
            count_next = count + (PTR_W + 1)'(1);
        else if (pop && !push)
            count_next = count - (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            cmd_ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]    <= cmd_wr;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
        if (pop) begin
            cur_addr  <= fifo_addr[rd_ptr];
            cur_wdata <= fifo_wdata[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            xa_wr_s <= 1'b0;
            xa_rd_s <= 1'b0;
            busy    <= !fifo_empty || (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (pop)
                        state <= next_issue;
                end
                S_WR: begin
                    xa_wr_s    <= 1'b1;
                    xa_addr    <= cur_addr;
                    xa_data_wr <= cur_wdata;
                    wr_cnt     <= wr_cnt + 16'd1;
                    if (GAP > 0) begin
                        state   <= S_GAPW;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state <= pop ? next_issue : S_IDLE;
                    end
                end
                S_RD: begin
                    xa_rd_s <= 1'b1;
                    xa_addr <= cur_addr;
                    rd_cnt  <= rd_cnt + 16'd1;
                    lat_cnt <= LAT_LOAD;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_rdata <= xa_data_rd;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (GAP > 0) begin
                            state   <= S_GAPW;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= pop ? next_issue : S_IDLE;
                        end
                    end
                end
                S_GAPW: begin
                    if (gap_cnt == 4'd0)
                        state <= pop ? next_issue : S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sif_xa_master.sv
// Bench for sif_xa_master: table-driven command stream plus hand sequences,
// with a strobe/response scoreboard and a fixed-latency X-side responder.
module tb_sif_xa_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        xa_wr_s;
    logic        xa_rd_s;
    logic [15:0] xa_addr;
    logic [15:0] xa_data_wr;
    logic [15:0] xa_data_rd = 16'hDEAD;
    logic        busy;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    sif_xa_master #(
        .AW(16), .DW(16), .RD_LAT(2), .GAP(0), .CMD_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
        .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rsp_q[$];
    int          wr_cyc_q[$];
    exp_t        e_mon;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int wr_n = 0, rd_n = 0, rsp_rises = 0;
    int last_wr_cyc = 0, last_rd_cyc = 0, rsp_rise_cyc = 0, hs_cyc = 0;
    logic rsp_prev = 1'b0;
    logic rd_d1 = 1'b0;
    logic [15:0] addr_d1 = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return a ^ 16'h1214;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event occurred that should not have", name);
    endtask

    // Responder: read data is valid only around the edge RD_LAT=2 after the strobe edge.
    always @(negedge clk) begin
        xa_data_rd = rd_d1 ? model_rd(addr_d1) : 16'hDEAD;
        rd_d1      = xa_rd_s;
        addr_d1    = xa_addr;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (xa_wr_s || xa_rd_s) begin
                check("strobe_exclusive", {31'd0, xa_wr_s & xa_rd_s}, 32'd0);
                if (xa_wr_s) begin wr_n++; last_wr_cyc = cyc; wr_cyc_q.push_back(cyc); end
                if (xa_rd_s) begin rd_n++; last_rd_cyc = cyc; end
                if (exp_q.size() == 0) fail("strobe_unexpected");
                else begin
                    e_mon = exp_q.pop_front();
                    check("strobe_kind", {31'd0, xa_wr_s}, {31'd0, e_mon.wr});
                    check("strobe_addr", {16'd0, xa_addr}, {16'd0, e_mon.addr});
                    if (e_mon.wr) check("strobe_wdata", {16'd0, xa_data_wr}, {16'd0, e_mon.data});
                    else rsp_q.push_back(e_mon.data);
                end
            end
            if (rsp_valid && !rsp_prev) begin rsp_rises++; rsp_rise_cyc = cyc; end
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc + 1;
                if (rsp_q.size() == 0) fail("rsp_unexpected");
                else check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rsp_q.pop_front()});
            end
            rsp_prev = rsp_valid;
        end else begin
            rsp_prev = 1'b0;
        end
    end

    task automatic send(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp);
        int n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) fail("send_timeout");
        else begin
            exp_q.push_back('{wr, a, exp});
            acc_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        @(negedge clk);
        while ((busy || rsp_valid || exp_q.size() != 0) && n < lim) begin
            @(negedge clk); n++;
        end
        check("idle_reached", {31'd0, (busy || rsp_valid || exp_q.size() != 0)}, 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];

    initial begin
        int wr0, n, rises0;
        logic [15:0] v0;

        vecs[0] = '{1'b1, 16'h0100, 16'hA5A5, 16'hA5A5};
        vecs[1] = '{1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0101, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{1'b0, 16'h00FF, 16'h0000, 16'h12EB};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'hEDEB};
        vecs[6] = '{1'b1, 16'h0000, 16'h1357, 16'h1357};
        vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'h1214};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_flags", {28'd0, xa_wr_s, xa_rd_s, rsp_valid, busy}, 32'd0);
        check("reset_xa_bus", {xa_addr, xa_data_wr}, 32'd0);
        check("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("reset_counters", {wr_cnt, rd_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write: strobe exactly at accept edge + 2.
        wr0 = wr_n;
        send(1'b1, 16'h0010, 16'hBEEF, 16'hBEEF);
        wait_idle(50);
        check("single_wr_cycle", last_wr_cyc, acc_cyc + 2);
        check("single_wr_strobes", wr_n - wr0, 1);
        check("single_wr_cnt", {16'd0, wr_cnt}, 32'd1);

        // Single read: response valid RD_LAT edges after the strobe.
        send(1'b0, 16'h0020, 16'h0000, 16'h1234);
        wait_idle(50);
        check("single_rd_strobe_cycle", last_rd_cyc, acc_cyc + 2);
        check("single_rd_rsp_cycle", rsp_rise_cyc, last_rd_cyc + 2);
        check("single_rd_cnt", {16'd0, rd_cnt}, 32'd1);

        for (int i = 0; i < 8; i++)
            send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        wait_idle(200);
        check("table_wr_cnt", {16'd0, wr_cnt}, 32'd5);
        check("table_rd_cnt", {16'd0, rd_cnt}, 32'd5);

        // Backpressure: a stalled response blocks the queued writes and fills the FIFO.
        rsp_ready = 1'b0;
        wr_cyc_q.delete();
        wr0 = wr_n;
        send(1'b0, 16'h0030, 16'h0000, model_rd(16'h0030));
        for (int i = 0; i < 4; i++)
            send(1'b1, 16'(i), 16'hC000 + 16'(i), 16'hC000 + 16'(i));
        check("burst_full_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'd4; cmd_wdata = 16'hC004;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        v0 = rsp_rdata;
        check("bp_rdata", {16'd0, v0}, {16'd0, model_rd(16'h0030)});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdata_stable", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, v0});
            check("bp_no_write", wr_n - wr0, 0);
            check("bp_still_full", {31'd0, cmd_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(1'b1, 16'd4, 16'hC004, 16'hC004);
        send(1'b1, 16'd5, 16'hC005, 16'hC005);
        wait_idle(100);
        check("burst_strobe_count", wr_cyc_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < wr_cyc_q.size()) check("burst_strobe_cycle", wr_cyc_q[i], hs_cyc + 1 + i);
        check("burst_wr_cnt", {16'd0, wr_cnt}, 32'd11);
        check("burst_rd_cnt", {16'd0, rd_cnt}, 32'd6);
        check("xa_bus_hold", {xa_addr, xa_data_wr}, {16'd5, 16'hC005});

        // Reset while the read waits for its data, with a write still queued.
        send(1'b0, 16'h0040, 16'h0000, model_rd(16'h0040));
        send(1'b1, 16'h0041, 16'h5555, 16'h5555);
        n = 0;
        wr0 = rd_n;
        @(negedge clk);
        while (rd_n == wr0 && n < 20) begin @(negedge clk); n++; end
        check("wait_rd_strobe_seen", rd_n - wr0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_strobes", {30'd0, xa_wr_s, xa_rd_s}, 32'd0);
        check("midrst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_counters", {wr_cnt, rd_cnt}, 32'd0);
        exp_q.delete();
        rsp_q.delete();
        rises0 = rsp_rises;
        wr0 = wr_n + rd_n;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_rsp", rsp_rises - rises0, 0);
        check("midrst_no_strobe", (wr_n + rd_n) - wr0, 0);
        check("midrst_fifo_empty", {30'd0, cmd_ready, busy}, 32'd2);
        @(posedge clk); #1;

        // Counter wrap: 65537 writes leave wr_cnt at 1.
        for (int i = 0; i < 65537; i++)
            send(1'b1, 16'(i), ~16'(i), ~16'(i));
        wait_idle(500);
        check("wrap_wr_cnt", {16'd0, wr_cnt}, 32'd1);
        check("wrap_rd_cnt", {16'd0, rd_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
